ula1bit_sliced: RTL and testbench



---
 rtl/ula1bit_sliced_pkg.sv | 31 +++
 rtl/ula1bit_sliced_if.sv | 47 ++++
 rtl/ula1bit_sliced_alu_slice.sv | 56 +++++
 rtl/ula1bit_sliced.sv | 77 +++++++
 tb/tb_ula1bit_sliced.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ula1bit_sliced_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-sliced ALU (ula1bit_sliced).
//
// Contents:
//   FN_AND / FN_OR / FN_NOTB / FN_ADD : 2-bit function codes, ordered {F0,F1}
//   fn_t                              : enum view of the same codes
//   WIDTH_MIN / WIDTH_MAX             : legal range of the WIDTH parameter
//   Z_FLAG_RST                        : value the zero flag takes in reset
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_OR   = 2'b01;
    localparam logic [1:0] FN_NOTB = 2'b10;
    localparam logic [1:0] FN_ADD  = 2'b11;

    typedef enum logic [1:0] {
        FN_E_AND  = FN_AND,
        FN_E_OR   = FN_OR,
        FN_E_NOTB = FN_NOTB,
        FN_E_ADD  = FN_ADD
    } fn_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // The reset result is all zeros, so the zero flag reads as set.
    localparam logic Z_FLAG_RST = 1'b1;

endpackage

// File: rtl/ula1bit_sliced_if.sv
// -----------------------------------------------------------------------------
// ula1bit_sliced_if
// Operand/control/result bundle of the bit-sliced ALU.
//
// Signals:
//   F0, F1    : function select, {F0,F1} uses the alu_pkg FN_* codes
//   ENA, ENB  : operand enables (0 forces that operand to zero)
//   INVA      : invert the gated A operand
//   INC       : carry into bit 0 (add mode only)
//   A, B      : WIDTH-bit operands
//   out       : registered result
//   carryout  : registered carry out of the MSB (add mode only)
//   n_flag    : registered out[WIDTH-1]
//   z_flag    : registered (out == 0)
//
// Modports:
//   master : drives operands/controls, observes results (bench / datapath)
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface ula1bit_sliced_if #(
    parameter int WIDTH = 1
);

    logic             F0;
    logic             F1;
    logic             ENA;
    logic             ENB;
    logic             INVA;
    logic             INC;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             carryout;
    logic             n_flag;
    logic             z_flag;

    modport master (
        output F0, F1, ENA, ENB, INVA, INC, A, B,
        input  out, carryout, n_flag, z_flag
    );

    modport slave (
        input  F0, F1, ENA, ENB, INVA, INC, A, B,
        output out, carryout, n_flag, z_flag
    );

endinterface

// File: rtl/ula1bit_sliced_alu_slice.sv
// -----------------------------------------------------------------------------
// alu_slice
// Combinational 1-bit ALU cell. WIDTH copies are chained through cin/cout.
//
// Ports:
//   a, b     : operand bits for this slice
//   ena, enb : operand enables
//   inva     : invert gated a
//   cin      : carry in from the next-lower slice (INC for slice 0)
//   f0, f1   : function select, {f0,f1}
//   r        : result bit
//   cout     : carry to the next-higher slice
// -----------------------------------------------------------------------------
module alu_slice
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ena,
    input  logic enb,
    input  logic inva,
    input  logic cin,
    input  logic f0,
    input  logic f1,
    output logic r,
    output logic cout
);

    logic w_a;
    logic w_b;

    // Gating uses AND so a disabled operand is a hard 0 even if the bus is X.
    assign w_a = (a & ena) ^ inva;
    assign w_b = b & enb;

    // cout is held at 0 outside add mode so the MSB carry is directly the
    // carryout value and a stray INC never leaks up the chain.
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case ({f0, f1})
            FN_AND:  r = w_a & w_b;
            FN_OR:   r = w_a | w_b;
            FN_NOTB: r = ~w_b;
            FN_ADD: begin
                r    = w_a ^ w_b ^ cin;
                cout = (w_a & w_b) | (cin & (w_a ^ w_b));
            end
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula1bit_sliced.sv
// -----------------------------------------------------------------------------
// ula1bit_sliced
// Registered Mic-1 style ALU built from a ripple chain of alu_slice cells.
// One cycle latency, a new operation every cycle, no handshake.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; clears out/carryout/n_flag and sets
//         z_flag, overriding whatever operation is presented that cycle
//   bus : ula1bit_sliced_if.slave, operands/controls in, registered results out
//
// Parameters:
//   WIDTH : operand/result width, 1..64
// -----------------------------------------------------------------------------
module ula1bit_sliced
    import alu_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    ula1bit_sliced_if.slave     bus
);

    logic [WIDTH-1:0] w_r;
    logic [WIDTH:0]   w_c;
    logic             w_n;
    logic             w_z;

    logic [WIDTH-1:0] r_out_p1;
    logic             r_carry_p1;
    logic             r_n_p1;
    logic             r_z_p1;

    assign w_c[0] = bus.INC;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        alu_slice u_slice (
            .a    (bus.A[gi]),
            .b    (bus.B[gi]),
            .ena  (bus.ENA),
            .enb  (bus.ENB),
            .inva (bus.INVA),
            .cin  (w_c[gi]),
            .f0   (bus.F0),
            .f1   (bus.F1),
            .r    (w_r[gi]),
            .cout (w_c[gi+1])
        );
    end

    // Flags come from the same combinational result that loads out, so all
    // four registers always describe one operation.
    assign w_n = w_r[WIDTH-1];
    assign w_z = ~|w_r;

    // ---- stage p0 (combinational slices) -> p1 (output registers) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_p1   <= '0;
            r_carry_p1 <= 1'b0;
            r_n_p1     <= 1'b0;
            r_z_p1     <= Z_FLAG_RST;
        end else begin
            r_out_p1   <= w_r;
            r_carry_p1 <= w_c[WIDTH];
            r_n_p1     <= w_n;
            r_z_p1     <= w_z;
        end
    end

    assign bus.out      = r_out_p1;
    assign bus.carryout = r_carry_p1;
    assign bus.n_flag   = r_n_p1;
    assign bus.z_flag   = r_z_p1;

endmodule

// File: tb/tb_ula1bit_sliced.sv
// -----------------------------------------------------------------------------
// tb_ula1bit_sliced
// Bench for ula1bit_sliced at WIDTH=1 and WIDTH=8 driven in lockstep.
// An arithmetic reference model predicts the registered outputs of both
// instances every cycle; directed vectors also carry hand-computed results.
// -----------------------------------------------------------------------------
module tb_ula1bit_sliced;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    ula1bit_sliced_if #(.WIDTH(1)) bus1 ();
    ula1bit_sliced_if #(.WIDTH(8)) bus8 ();

    ula1bit_sliced #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    ula1bit_sliced #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {carry, n, z, result[63:0]} for a w-bit ALU.
    function automatic logic [66:0] model(input int w, input logic [1:0] f,
                                          input logic ena, input logic enb,
                                          input logic inva, input logic inc,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [64:0] mask;
        logic [64:0] ag;
        logic [64:0] bg;
        logic [64:0] res;
        logic        c;
        mask = (65'd1 << w) - 65'd1;
        ag   = ena ? {1'b0, a} : 65'd0;
        if (inva) ag = ~ag;
        ag   = ag & mask;
        bg   = (enb ? {1'b0, b} : 65'd0) & mask;
        c    = 1'b0;
        case (f)
            2'b00:   res = ag & bg;
            2'b01:   res = ag | bg;
            2'b10:   res = ~bg & mask;
            default: begin
                res = ag + bg + {64'd0, inc};
                c   = res[w];
                res = res & mask;
            end
        endcase
        return {c, res[w-1], (res == 65'd0), res[63:0]};
    endfunction

    logic [66:0] exp1;
    logic [66:0] exp8;
    logic        model_vld;

    initial model_vld = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp1 <= {1'b0, 1'b0, 1'b1, 64'd0};
            exp8 <= {1'b0, 1'b0, 1'b1, 64'd0};
        end else begin
            exp1 <= model(1, {bus1.F0, bus1.F1}, bus1.ENA, bus1.ENB, bus1.INVA, bus1.INC,
                          {63'd0, bus1.A}, {63'd0, bus1.B});
            exp8 <= model(8, {bus8.F0, bus8.F1}, bus8.ENA, bus8.ENB, bus8.INVA, bus8.INC,
                          {56'd0, bus8.A}, {56'd0, bus8.B});
        end
        model_vld <= 1'b1;
    end

    // Cycle-by-cycle comparison on the falling edge, away from the update.
    always @(negedge clk) begin
        if (model_vld) begin
            n_tests++;
            if ({bus1.carryout, bus1.n_flag, bus1.z_flag, bus1.out} !== {exp1[66:64], exp1[0]}) begin
                n_fail++;
                $display("FAIL model_w1 t=%0t got c/n/z/out=%b%b%b %h want %b%b%b %h", $time,
                         bus1.carryout, bus1.n_flag, bus1.z_flag, bus1.out,
                         exp1[66], exp1[65], exp1[64], exp1[0]);
            end
            n_tests++;
            if ({bus8.carryout, bus8.n_flag, bus8.z_flag, bus8.out} !== {exp8[66:64], exp8[7:0]}) begin
                n_fail++;
                $display("FAIL model_w8 t=%0t got c/n/z/out=%b%b%b %h want %b%b%b %h", $time,
                         bus8.carryout, bus8.n_flag, bus8.z_flag, bus8.out,
                         exp8[66], exp8[65], exp8[64], exp8[7:0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic drive(input logic [1:0] f, input logic ena, input logic enb,
                         input logic inva, input logic inc,
                         input logic [7:0] a, input logic [7:0] b);
        bus1.F0 = f[1]; bus1.F1 = f[0];
        bus1.ENA = ena; bus1.ENB = enb; bus1.INVA = inva; bus1.INC = inc;
        bus1.A = a[0];  bus1.B = b[0];
        bus8.F0 = f[1]; bus8.F1 = f[0];
        bus8.ENA = ena; bus8.ENB = enb; bus8.INVA = inva; bus8.INC = inc;
        bus8.A = a;     bus8.B = b;
    endtask

    typedef struct {
        logic [1:0] f;
        logic       ena, enb, inva, inc;
        logic [7:0] a, b;
        logic [7:0] out;
        logic       c;
    } vec_t;

    // WIDTH=1 vectors, A=1 B=1.
    vec_t v1 [10] = '{
        '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 1'b0},
        '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0},
        '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0},
        '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 1'b0},
        '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0},
        '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1},
        '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1},
        '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1},
        '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b0},
        '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h01, 1'b0}
    };

    // WIDTH=8 vectors.
    vec_t v8 [4] = '{
        '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1},
        '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h05, 8'h05, 1'b1},
        '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h05, 8'h02, 1'b1},
        '{2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'hFE, 1'b0}
    };

    // Back-to-back function sweep with A=C3, B=5A, INC=1 on the 8-bit unit.
    logic [7:0] b2b_out [4] = '{8'h42, 8'hDB, 8'hA5, 8'h1E};
    logic       b2b_c   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out8",  {24'd0, bus8.out}, 32'h00);
        check("rst_c8",    {31'd0, bus8.carryout}, 32'd0);
        check("rst_n8",    {31'd0, bus8.n_flag}, 32'd0);
        check("rst_z8",    {31'd0, bus8.z_flag}, 32'd1);
        check("rst_z1",    {31'd0, bus1.z_flag}, 32'd1);

        @(negedge clk);
        rst = 1'b0;

        foreach (v1[i]) begin
            @(negedge clk);
            drive(v1[i].f, v1[i].ena, v1[i].enb, v1[i].inva, v1[i].inc, v1[i].a, v1[i].b);
            @(posedge clk);
            #1;
            check($sformatf("w1_out_%0d", i), {31'd0, bus1.out}, {31'd0, v1[i].out[0]});
            check($sformatf("w1_c_%0d", i), {31'd0, bus1.carryout}, {31'd0, v1[i].c});
        end

        foreach (v8[i]) begin
            @(negedge clk);
            drive(v8[i].f, v8[i].ena, v8[i].enb, v8[i].inva, v8[i].inc, v8[i].a, v8[i].b);
            @(posedge clk);
            #1;
            check($sformatf("w8_out_%0d", i), {24'd0, bus8.out}, {24'd0, v8[i].out});
            check($sformatf("w8_c_%0d", i), {31'd0, bus8.carryout}, {31'd0, v8[i].c});
        end
        // The last vector above produced FE: negative, nonzero.
        check("w8_n_neg", {31'd0, bus8.n_flag}, 32'd1);
        check("w8_z_neg", {31'd0, bus8.z_flag}, 32'd0);

        // FF+01 wraps to zero: z set, n clear.
        @(negedge clk);
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h01);
        @(posedge clk);
        #1;
        check("wrap_z", {31'd0, bus8.z_flag}, 32'd1);
        check("wrap_n", {31'd0, bus8.n_flag}, 32'd0);

        // Reset in the middle of a nonzero operation stream.
        @(negedge clk);
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h83, 8'h05);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out", {24'd0, bus8.out}, 32'h00);
        check("mid_rst_z",   {31'd0, bus8.z_flag}, 32'd1);
        check("mid_rst_n",   {31'd0, bus8.n_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_out", {24'd0, bus8.out}, 32'h88);
        check("post_rst_n",   {31'd0, bus8.n_flag}, 32'd1);

        // Change F every cycle; each result must land exactly one edge later.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(k[1:0], 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h5A);
            @(posedge clk);
            #1;
            check($sformatf("b2b_out_%0d", k), {24'd0, bus8.out}, {24'd0, b2b_out[k]});
            check($sformatf("b2b_c_%0d", k), {31'd0, bus8.carryout}, {31'd0, b2b_c[k]});
        end

        // Random traffic, checked by the reference model only.
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            drive(2'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 8'($urandom), 8'($urandom));
            if (k == 120) rst = 1'b1;
            if (k == 121) rst = 1'b0;
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
